gate_pipe_n: RTL and testbench

GATE_PIPE_N -- requirements
Module: gate_pipe_n

---
 rtl/gate_pipe_n.sv | 106 ++++++++++
 tb/tb_gate_pipe_n.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_pipe_n.sv
`default_nettype none
// ============================================================================
// gate_pipe_n : two-stage elastic pipeline computing bitwise A op B and op-reduction of A
// Revision    : 1.0
// ============================================================================
module gate_pipe_n #(
   parameter int WIDTH = 8,
   parameter int OPW   = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [OPW-1:0]   in_op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_vec,
   output logic             out_red,
   output logic             out_err
);

   localparam logic [OPW-1:0] c_OP_AND  = OPW'(0);
   localparam logic [OPW-1:0] c_OP_OR   = OPW'(1);
   localparam logic [OPW-1:0] c_OP_XOR  = OPW'(2);
   localparam logic [OPW-1:0] c_OP_NAND = OPW'(3);
   localparam logic [OPW-1:0] c_OP_NOR  = OPW'(4);
   localparam logic [OPW-1:0] c_OP_XNOR = OPW'(5);
   localparam logic [OPW-1:0] c_OP_ILL  = OPW'(6);

   logic             r_s1_valid;
   logic [WIDTH-1:0] r_s1_a;
   logic [WIDTH-1:0] r_s1_b;
   logic [OPW-1:0]   r_s1_op;
   logic             r_s2_valid;
   logic [WIDTH-1:0] r_s2_vec;
   logic             r_s2_red;
   logic             r_err;

   logic             w_s2_ready;
   logic             w_s1_ready;
   logic             w_in_fire;
   logic [WIDTH-1:0] w_vec;
   logic             w_red;

   assign w_s2_ready = ~r_s2_valid | out_ready;
   assign w_s1_ready = ~r_s1_valid | w_s2_ready;
   // Gated by rst so upstream never sees ready while the pipeline is held in reset.
   assign in_ready   = w_s1_ready & ~rst;
   assign w_in_fire  = in_valid & in_ready;

   always_comb begin
      w_vec = '0;
      w_red = 1'b0;
      case (r_s1_op)
         c_OP_AND:  begin w_vec = r_s1_a & r_s1_b;    w_red = &r_s1_a;  end
         c_OP_OR:   begin w_vec = r_s1_a | r_s1_b;    w_red = |r_s1_a;  end
         c_OP_XOR:  begin w_vec = r_s1_a ^ r_s1_b;    w_red = ^r_s1_a;  end
         c_OP_NAND: begin w_vec = ~(r_s1_a & r_s1_b); w_red = ~&r_s1_a; end
         c_OP_NOR:  begin w_vec = ~(r_s1_a | r_s1_b); w_red = ~|r_s1_a; end
         c_OP_XNOR: begin w_vec = ~(r_s1_a ^ r_s1_b); w_red = ~^r_s1_a; end
         default:   begin w_vec = '0;                 w_red = 1'b0;     end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_s1_a     <= '0;
         r_s1_b     <= '0;
         r_s1_op    <= '0;
         r_s2_valid <= 1'b0;
         r_s2_vec   <= '0;
         r_s2_red   <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         if (w_s1_ready) begin
            r_s1_valid <= in_valid;
         end
         if (w_in_fire) begin
            r_s1_a  <= in_a;
            r_s1_b  <= in_b;
            r_s1_op <= in_op;
         end
         if (w_s2_ready) begin
            r_s2_valid <= r_s1_valid;
         end
         if (r_s1_valid && w_s2_ready) begin
            r_s2_vec <= w_vec;
            r_s2_red <= w_red;
         end
         // Sticky until reset; flagged as the illegal opcode enters S1.
         if (w_in_fire && (in_op >= c_OP_ILL)) begin
            r_err <= 1'b1;
         end
      end
   end

   assign out_valid = r_s2_valid;
   assign out_vec   = r_s2_vec;
   assign out_red   = r_s2_red;
   assign out_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_gate_pipe_n.sv
`default_nettype none
// ============================================================================
// tb_gate_pipe_n : directed and random checking of gate_pipe_n against a queue model
// Revision       : 1.0
// ============================================================================
module tb_gate_pipe_n;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_a;
   logic [7:0] in_b;
   logic [2:0] in_op;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_vec;
   logic       out_red;
   logic       out_err;

   gate_pipe_n #(.WIDTH(8), .OPW(3)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_op     (in_op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_vec   (out_vec),
      .out_red   (out_red),
      .out_err   (out_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] vec;
      logic       red;
      int         cyc;
   } ent_t;

   int   checks   = 0;
   int   failures = 0;
   int   accepted = 0;
   int   emitted  = 0;
   int   cyc      = 0;
   ent_t q[$];
   ent_t e;
   logic err_exp    = 1'b0;
   logic stall_prev = 1'b0;
   logic exp_ov;
   logic [7:0] prev_vec;
   logic       prev_red;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic ent_t golden(input logic [7:0] a, input logic [7:0] b,
                                   input logic [2:0] op, input int c);
      ent_t r;
      r.cyc = c;
      case (op)
         3'd0:    begin r.vec = a & b;    r.red = (a == 8'hFF);             end
         3'd1:    begin r.vec = a | b;    r.red = (a != 8'h00);             end
         3'd2:    begin r.vec = a ^ b;    r.red = ($countones(a) % 2 == 1); end
         3'd3:    begin r.vec = ~(a & b); r.red = (a != 8'hFF);             end
         3'd4:    begin r.vec = ~(a | b); r.red = (a == 8'h00);             end
         3'd5:    begin r.vec = ~(a ^ b); r.red = ($countones(a) % 2 == 0); end
         default: begin r.vec = 8'h00;    r.red = 1'b0;                     end
      endcase
      return r;
   endfunction

   // Model: FIFO of results tagged with acceptance cycle; a result is visible two cycles later.
   always @(negedge clk) begin
      if (rst) begin
         q.delete();
         err_exp    = 1'b0;
         stall_prev = 1'b0;
         chk("rst_out_valid", out_valid, 0);
         chk("rst_out_vec", out_vec, 0);
         chk("rst_out_red", out_red, 0);
         chk("rst_out_err", out_err, 0);
         chk("rst_in_ready", in_ready, 0);
      end else begin
         chk("in_ready", in_ready, (q.size() < 2) || out_ready);
         exp_ov = (q.size() > 0) && (q[0].cyc + 2 <= cyc);
         chk("out_valid", out_valid, exp_ov);
         chk("out_err", out_err, err_exp);
         if (stall_prev) begin
            chk("hold_vec", out_vec, prev_vec);
            chk("hold_red", out_red, prev_red);
         end
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL spurious_output: got vec %0h with no pending transaction", out_vec);
            end else begin
               e = q.pop_front();
               chk("out_vec", out_vec, e.vec);
               chk("out_red", out_red, e.red);
            end
            emitted++;
         end
         if (in_valid && in_ready) begin
            q.push_back(golden(in_a, in_b, in_op, cyc));
            accepted++;
            if (in_op > 3'd5) err_exp = 1'b1;
         end
         stall_prev = out_valid & ~out_ready;
         prev_vec   = out_vec;
         prev_red   = out_red;
      end
      cyc++;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   int base_acc;
   int base_emit;
   int n;

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      in_a = 8'h00; in_b = 8'h00; in_op = 3'd0;
      repeat (3) step();
      rst = 1'b0;

      // XOR with two-cycle latency
      in_valid = 1'b1; in_a = 8'hF0; in_b = 8'h3C; in_op = 3'd2;
      step();
      in_valid = 1'b0;
      chk("t33_not_yet", out_valid, 0);
      step();
      chk("t33_valid", out_valid, 1);
      chk("t33_vec", out_vec, 8'hCC);
      chk("t33_red", out_red, 0);
      step();

      // back-to-back NAND then AND reductions, no bubble
      in_valid = 1'b1; in_a = 8'hFF; in_b = 8'h00; in_op = 3'd3;
      step();
      in_op = 3'd0;
      step();
      in_valid = 1'b0;
      chk("t34_v0", out_valid, 1);
      chk("t34_red0", out_red, 0);
      step();
      chk("t34_v1", out_valid, 1);
      chk("t34_red1", out_red, 1);
      step();

      // backpressure with three offered transactions
      base_emit = emitted;
      out_ready = 1'b0;
      in_valid = 1'b1; in_a = 8'h0F; in_b = 8'h33; in_op = 3'd0;
      step();
      in_a = 8'h11; in_b = 8'h22; in_op = 3'd1;
      step();
      in_a = 8'h80; in_b = 8'h01; in_op = 3'd2;
      chk("t35_full_ready", in_ready, 0);
      step();
      chk("t35_still_full", in_ready, 0);
      chk("t35_valid", out_valid, 1);
      chk("t35_vec", out_vec, 8'h03);
      chk("t35_red", out_red, 0);
      step();
      chk("t35_hold_vec", out_vec, 8'h03);
      out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      repeat (4) step();
      chk("t35_all_out", emitted - base_emit, 3);

      // illegal opcode then OR
      in_valid = 1'b1; in_a = 8'hAA; in_b = 8'h0F; in_op = 3'd6;
      chk("t36_err_before", out_err, 0);
      step();
      chk("t36_err_rise", out_err, 1);
      in_a = 8'hAA; in_b = 8'h55; in_op = 3'd1;
      step();
      in_valid = 1'b0;
      chk("t36_ill_valid", out_valid, 1);
      chk("t36_ill_vec", out_vec, 8'h00);
      chk("t36_ill_red", out_red, 0);
      step();
      chk("t36_or_vec", out_vec, 8'hFF);
      chk("t36_or_red", out_red, 1);
      chk("t36_err_sticky", out_err, 1);
      step();

      // reset with both stages full
      out_ready = 1'b0;
      in_valid = 1'b1; in_a = 8'h5A; in_b = 8'hA5; in_op = 3'd5;
      step();
      in_op = 3'd4;
      step();
      in_valid = 1'b0;
      chk("t37_full_valid", out_valid, 1);
      chk("t37_err_pre", out_err, 1);
      #1 rst = 1'b1;
      #1;
      chk("t37_async_valid", out_valid, 0);
      chk("t37_async_err", out_err, 0);
      chk("t37_async_ready", in_ready, 0);
      step();
      rst = 1'b0;
      out_ready = 1'b1;
      repeat (4) step();
      chk("t37_no_stale", out_valid, 0);

      // random valid/ready traffic
      base_acc  = accepted;
      base_emit = emitted;
      n = 0;
      while ((accepted - base_acc) < 10000 && n < 60000) begin
         in_valid  = ($urandom_range(0, 9) < 7);
         out_ready = ($urandom_range(0, 9) < 7);
         in_a      = 8'($urandom_range(0, 255));
         in_b      = 8'($urandom_range(0, 255));
         in_op     = 3'($urandom_range(0, 7));
         step();
         n++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      n = 0;
      while (q.size() > 0 && n < 20) begin
         step();
         n++;
      end
      chk("rand_target_reached", ((accepted - base_acc) >= 10000), 1);
      chk("rand_acc_eq_emit", accepted - base_acc, emitted - base_emit);
      chk("rand_drained", q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
